// File: rtl/rgb_slice_writer.sv
// rgb_slice_writer
// Packs 24-bit RGB pixels into 16-bit RAM words and writes whole slices into
// a ring of SLICES_IN_RAM slots. Tracks committed-but-unread slices (fill),
// raises stream_ready once enough are buffered, and flags dropped (overrun)
// and aborted (frame_error) frames until reset.
module rgb_slice_writer #(
  parameter int unsigned RAM_ADDR_WIDTH = 32,
  parameter int unsigned RAM_DATA_WIDTH = 16,
  parameter int unsigned RAM_BASE       = 0,
  parameter int unsigned SLICES_IN_RAM  = 18,
  parameter int unsigned IMAGE_SIZE     = 1920,
  parameter int unsigned READY_SLICES   = 2
) (
  input  logic                               clk_33,
  input  logic                               rst,
  input  logic [23:0]                        rgb,
  input  logic                               de,
  input  logic                               vsync,
  input  logic                               slice_consumed,
  output logic [RAM_ADDR_WIDTH-1:0]          ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]          ram_data,
  output logic                               ram_we,
  output logic                               stream_ready,
  output logic [$clog2(SLICES_IN_RAM+1)-1:0] fill,
  output logic                               overrun,
  output logic                               frame_error
);

  localparam int unsigned FILL_W = $clog2(SLICES_IN_RAM + 1);
  localparam int unsigned SLOT_W = (SLICES_IN_RAM > 1) ? $clog2(SLICES_IN_RAM) : 1;
  localparam int unsigned PIX_W  = $clog2(IMAGE_SIZE + 1);

  localparam logic [FILL_W-1:0]         FILL_MAX    = FILL_W'(SLICES_IN_RAM);
  localparam logic [FILL_W-1:0]         FILL_READY  = FILL_W'(READY_SLICES);
  localparam logic [FILL_W-1:0]         FILL_ZERO   = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0]         FILL_ONE    = FILL_W'(1);
  localparam logic [SLOT_W-1:0]         SLOT_LAST   = SLOT_W'(SLICES_IN_RAM - 1);
  localparam logic [SLOT_W-1:0]         SLOT_ZERO   = {SLOT_W{1'b0}};
  localparam logic [SLOT_W-1:0]         SLOT_ONE    = SLOT_W'(1);
  localparam logic [PIX_W-1:0]          PIX_LAST    = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [PIX_W-1:0]          PIX_END     = PIX_W'(IMAGE_SIZE);
  localparam logic [PIX_W-1:0]          PIX_ZERO    = {PIX_W{1'b0}};
  localparam logic [PIX_W-1:0]          PIX_ONE     = PIX_W'(1);
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_BASE   = RAM_ADDR_WIDTH'(RAM_BASE);
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_STRIDE = RAM_ADDR_WIDTH'(IMAGE_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  // RGB888 -> {B5, G5, 0, R5}; blue on top, a zero pad bit between green and red
  function automatic logic [15:0] pack_rgb(input logic [23:0] px);
    pack_rgb = {px[7:3], px[15:11], 1'b0, px[23:19]};
  endfunction

  state_t                    state_r;
  logic [SLOT_W-1:0]         wr_slot_r;
  logic [PIX_W-1:0]          pix_idx_r;
  logic [FILL_W-1:0]         fill_r;
  logic                      vsync_q_r;
  logic                      run_r;
  logic                      stream_ready_r;
  logic                      overrun_r;
  logic                      frame_error_r;
  logic                      ram_we_r;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_r;
  logic [RAM_DATA_WIDTH-1:0] ram_data_r;

  logic                      vsync_edge_s;
  logic                      has_room_s;
  logic                      accept_s;
  logic                      commit_s;
  logic                      consume_s;
  logic [FILL_W-1:0]         fill_next_s;
  logic [SLOT_W-1:0]         slot_next_s;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr_s;

  // Per-cycle decode: vsync edge, pixel acceptance, commit and fill bookkeeping
  always_comb begin
    vsync_edge_s = 1'b0;
    has_room_s   = 1'b0;
    accept_s     = 1'b0;
    commit_s     = 1'b0;
    consume_s    = 1'b0;
    fill_next_s  = fill_r;
    slot_next_s  = wr_slot_r;
    wr_addr_s    = ADDR_BASE;

    // run_r masks the first cycle after reset so a vsync already high then
    // is not mistaken for a fresh edge
    vsync_edge_s = run_r & vsync & ~vsync_q_r;
    has_room_s   = (fill_r < FILL_MAX);

    // An edge in WRITE aborts the slice, so the pixel on that cycle is dropped
    if ((state_r == ST_WRITE) && !vsync_edge_s && de && (pix_idx_r < PIX_END)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end

    commit_s  = accept_s && (pix_idx_r == PIX_LAST);
    consume_s = slice_consumed && (fill_r != FILL_ZERO);

    case ({commit_s, consume_s})
      2'b10:   fill_next_s = fill_r + FILL_ONE;
      2'b01:   fill_next_s = fill_r - FILL_ONE;
      default: fill_next_s = fill_r;
    endcase

    if (wr_slot_r == SLOT_LAST) begin
      slot_next_s = SLOT_ZERO;
    end else begin
      slot_next_s = wr_slot_r + SLOT_ONE;
    end

    wr_addr_s = ADDR_BASE
              + (RAM_ADDR_WIDTH'(wr_slot_r) * ADDR_STRIDE)
              + RAM_ADDR_WIDTH'(pix_idx_r);
  end

  // vsync history for edge detection and the post-reset arming flag
  always_ff @(posedge clk_33) begin
    if (rst) begin
      vsync_q_r <= 1'b0;
      run_r     <= 1'b0;
    end else begin
      vsync_q_r <= vsync;
      run_r     <= 1'b1;
    end
  end

  // Slice-writer FSM: slot/pixel counters, fill, sticky flags and RAM port
  always_ff @(posedge clk_33) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wr_slot_r     <= SLOT_ZERO;
      pix_idx_r     <= PIX_ZERO;
      fill_r        <= FILL_ZERO;
      overrun_r     <= 1'b0;
      frame_error_r <= 1'b0;
      ram_we_r      <= 1'b0;
      ram_addr_r    <= ADDR_BASE;
      ram_data_r    <= {RAM_DATA_WIDTH{1'b0}};
    end else begin
      fill_r   <= fill_next_s;
      ram_we_r <= accept_s;
      if (accept_s) begin
        ram_addr_r <= wr_addr_s;
        ram_data_r <= RAM_DATA_WIDTH'(pack_rgb(rgb));
      end

      case (state_r)
        ST_IDLE: begin
          if (vsync_edge_s) begin
            pix_idx_r <= PIX_ZERO;
            if (has_room_s) begin
              state_r <= ST_WRITE;
            end else begin
              state_r   <= ST_DROP;
              overrun_r <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (vsync_edge_s) begin
            // Short frame: restart the same slot, fill and wr_slot untouched
            if (pix_idx_r < PIX_END) begin
              frame_error_r <= 1'b1;
            end
            pix_idx_r <= PIX_ZERO;
            if (has_room_s) begin
              state_r <= ST_WRITE;
            end else begin
              state_r   <= ST_DROP;
              overrun_r <= 1'b1;
            end
          end else if (commit_s) begin
            pix_idx_r <= PIX_ZERO;
            wr_slot_r <= slot_next_s;
            state_r   <= ST_IDLE;
          end else if (accept_s) begin
            pix_idx_r <= pix_idx_r + PIX_ONE;
          end
        end

        ST_DROP: begin
          // Frame is being discarded; the next edge re-checks for room
          if (vsync_edge_s) begin
            pix_idx_r <= PIX_ZERO;
            if (has_room_s) begin
              state_r <= ST_WRITE;
            end else begin
              state_r   <= ST_DROP;
              overrun_r <= 1'b1;
            end
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          pix_idx_r <= PIX_ZERO;
        end
      endcase
    end
  end

  // stream_ready: set once fill reaches the threshold, cleared when drained
  always_ff @(posedge clk_33) begin
    if (rst) begin
      stream_ready_r <= 1'b0;
    end else if (fill_r >= FILL_READY) begin
      stream_ready_r <= 1'b1;
    end else if (fill_r == FILL_ZERO) begin
      stream_ready_r <= 1'b0;
    end else begin
      stream_ready_r <= stream_ready_r;
    end
  end

  assign ram_we       = ram_we_r;
  assign ram_addr     = ram_addr_r;
  assign ram_data     = ram_data_r;
  assign fill         = fill_r;
  assign stream_ready = stream_ready_r;
  assign overrun      = overrun_r;
  assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_rgb_slice_writer.sv
// Directed self-checking bench for rgb_slice_writer at default parameters.
module tb_rgb_slice_writer;

  logic        clk_33;
  logic        rst;
  logic [23:0] rgb;
  logic        de;
  logic        vsync;
  logic        slice_consumed;
  logic [31:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic        stream_ready;
  logic [4:0]  fill;
  logic        overrun;
  logic        frame_error;

  int          n_cmp;
  int          n_bad;
  int          wr_total;
  logic        we_d;
  logic [31:0] start_addr;
  logic [31:0] last_addr;
  int          base_wr;

  rgb_slice_writer dut (
    .clk_33         (clk_33),
    .rst            (rst),
    .rgb            (rgb),
    .de             (de),
    .vsync          (vsync),
    .slice_consumed (slice_consumed),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .ram_we         (ram_we),
    .stream_ready   (stream_ready),
    .fill           (fill),
    .overrun        (overrun),
    .frame_error    (frame_error)
  );

  // free-running clock
  initial begin
    clk_33 = 1'b0;
    forever #5 clk_33 = ~clk_33;
  end

  // write monitor sampled on the falling edge
  always @(negedge clk_33) begin
    we_d <= ram_we;
    if (ram_we) begin
      wr_total  <= wr_total + 1;
      last_addr <= ram_addr;
      if (!we_d) begin
        start_addr <= ram_addr;
      end
    end
  end

  // runaway guard
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_33);
    #1;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic send_px(input int n, input logic [23:0] c);
    for (int i = 0; i < n; i++) begin
      de  = 1'b1;
      rgb = c;
      tick();
    end
    de = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    wr_total = 0; we_d = 1'b0; start_addr = 32'd0; last_addr = 32'd0;
    rst = 1'b1; rgb = 24'h000000; de = 1'b0; vsync = 1'b1; slice_consumed = 1'b0;

    // reset state, with vsync held high across reset release
    tick(); tick(); tick();
    chk("rst_we",    {31'd0, ram_we},       32'd0);
    chk("rst_addr",  ram_addr,              32'd0);
    chk("rst_data",  {16'd0, ram_data},     32'd0);
    chk("rst_fill",  {27'd0, fill},         32'd0);
    chk("rst_ready", {31'd0, stream_ready}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun},      32'd0);
    chk("rst_ferr",  {31'd0, frame_error},  32'd0);
    rst = 1'b0;
    tick(); tick();
    base_wr = wr_total;
    de = 1'b1; tick(); tick(); de = 1'b0; tick();
    chk("vsync_high_at_release_no_write", wr_total - base_wr, 32'd0);
    vsync = 1'b0; tick(); tick();

    // slice 0: packing check on the first two pixels
    base_wr = wr_total;
    vsync_pulse();
    de = 1'b1; rgb = 24'hF8FCF8; tick();
    chk("pack_we",   {31'd0, ram_we},   32'd1);
    chk("pack_addr", ram_addr,          32'd0);
    chk("pack_data", {16'd0, ram_data}, 32'h0000FFDF);
    rgb = 24'h123456; tick();
    chk("pack2_addr", ram_addr,          32'd1);
    chk("pack2_data", {16'd0, ram_data}, 32'h00005182);
    send_px(1918, 24'h00FF00);
    chk("s0_fill", {27'd0, fill}, 32'd1);
    tick();
    chk("s0_last",   last_addr,             32'd1919);
    chk("s0_count",  wr_total - base_wr,    32'd1920);
    chk("s0_ready",  {31'd0, stream_ready}, 32'd0);

    // de after commit but before vsync is discarded
    base_wr = wr_total;
    de = 1'b1; tick(); tick(); de = 1'b0; tick();
    chk("post_commit_de", wr_total - base_wr, 32'd0);

    // slice 1: second slot, stream_ready one cycle after commit
    vsync_pulse();
    send_px(1920, 24'h0000FF);
    chk("s1_fill",        {27'd0, fill},         32'd2);
    chk("s1_ready_early", {31'd0, stream_ready}, 32'd0);
    tick();
    chk("s1_ready", {31'd0, stream_ready}, 32'd1);
    chk("s1_start", start_addr,            32'd1920);
    chk("s1_last",  last_addr,             32'd3839);

    // short frame: abort after 100 pixels, restart the same slot
    vsync_pulse();
    send_px(100, 24'hFF0000);
    vsync_pulse();
    chk("short_ferr", {31'd0, frame_error}, 32'd1);
    chk("short_fill", {27'd0, fill},        32'd2);
    de = 1'b1; rgb = 24'h808080; tick();
    chk("short_restart_we",   {31'd0, ram_we}, 32'd1);
    chk("short_restart_addr", ram_addr,        32'd3840);
    send_px(1918, 24'h808080);
    de = 1'b1; slice_consumed = 1'b1; tick();
    de = 1'b0; slice_consumed = 1'b0;
    chk("commit_and_consume_fill", {27'd0, fill}, 32'd2);
    tick();
    chk("s2_last", last_addr, 32'd5759);

    // drain: two consumes, a third at fill=0 is ignored
    slice_consumed = 1'b1; tick();
    chk("drain_fill1", {27'd0, fill}, 32'd1);
    tick();
    chk("drain_fill0",   {27'd0, fill},         32'd0);
    chk("drain_ready_h", {31'd0, stream_ready}, 32'd1);
    tick();
    slice_consumed = 1'b0;
    chk("consume_at_empty", {27'd0, fill},         32'd0);
    chk("drain_ready_l",    {31'd0, stream_ready}, 32'd0);
    chk("ferr_sticky",      {31'd0, frame_error},  32'd1);
    chk("no_overrun_yet",   {31'd0, overrun},      32'd0);

    // reset in the middle of a slice, at pixel 500, with de still high
    vsync_pulse();
    send_px(500, 24'h404040);
    de = 1'b1; rst = 1'b1; tick();
    chk("mid_rst_we",    {31'd0, ram_we},       32'd0);
    chk("mid_rst_addr",  ram_addr,              32'd0);
    chk("mid_rst_data",  {16'd0, ram_data},     32'd0);
    chk("mid_rst_fill",  {27'd0, fill},         32'd0);
    chk("mid_rst_ready", {31'd0, stream_ready}, 32'd0);
    chk("mid_rst_ferr",  {31'd0, frame_error},  32'd0);
    rst = 1'b0; de = 1'b0; tick(); tick();

    // fill every slot with no consume: checks slot 0 and wrap to slot 17
    for (int s = 0; s < 18; s++) begin
      vsync_pulse();
      send_px(1920, 24'hFFFFFF);
      tick();
      if (s == 0) chk("full_s0_start", start_addr, 32'd0);
      if (s == 17) begin
        chk("full_s17_start", start_addr, 32'd32640);
        chk("full_s17_last",  last_addr,  32'd34559);
      end
    end
    chk("full_fill",  {27'd0, fill},         32'd18);
    chk("full_ready", {31'd0, stream_ready}, 32'd1);
    chk("full_ovr0",  {31'd0, overrun},      32'd0);

    // frame arriving with RAM full is dropped
    base_wr = wr_total;
    vsync_pulse();
    send_px(1920, 24'h111111);
    tick();
    chk("drop_no_write", wr_total - base_wr, 32'd0);
    chk("drop_overrun",  {31'd0, overrun},   32'd1);
    chk("drop_fill",     {27'd0, fill},      32'd18);

    // one consume frees a slot; next frame wraps to slot 0
    slice_consumed = 1'b1; tick(); slice_consumed = 1'b0;
    chk("resume_fill_before", {27'd0, fill}, 32'd17);
    vsync_pulse();
    send_px(1920, 24'h222222);
    tick();
    chk("resume_start",    start_addr,       32'd0);
    chk("resume_last",     last_addr,        32'd1919);
    chk("resume_fill",     {27'd0, fill},    32'd18);
    chk("overrun_sticky",  {31'd0, overrun}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_slice_writer.md
RGB_SLICE_WRITER -- requirements
Module: rgb_slice_writer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- RAM_ADDR_WIDTH, 32, RAM address width.
- RAM_DATA_WIDTH, 16, RAM word width.
- RAM_BASE, 0, address of slot 0.
- SLICES_IN_RAM, 18, number of slice slots in RAM.
- IMAGE_SIZE, 1920, pixels per slice (40x48).
- READY_SLICES, 2, committed slices needed before streaming.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk_33, in, 1, sole clock.
- rst, in, 1, reset; synchronous, active-high.
- rgb, in, 24, pixel {R[23:16],G[15:8],B[7:0]}.
- de, in, 1, pixel valid.
- vsync, in, 1, frame sync; rising edge starts a slice.
- slice_consumed, in, 1, one-cycle pulse from the reader; one slot freed.
- ram_addr, out, RAM_ADDR_WIDTH, write address.
- ram_data, out, RAM_DATA_WIDTH, write data.
- ram_we, out, 1, write strobe.
- stream_ready, out, 1, enough slices buffered for the reader.
- fill, out, $clog2(SLICES_IN_RAM+1), committed unread slices.
- overrun, out, 1, sticky: frame dropped because RAM was full.
- frame_error, out, 1, sticky: short frame aborted.

Function
REQ-003 Pixel packing SHALL be ram_data = {B[7:3], G[7:3], 1'b0, R[7:3]}, so blue sits at bits 15:11, green at 10:6, bit 5 is 0, and red sits at 4:0.
REQ-004 A vsync rising edge SHALL be detected against a registered copy of vsync; vsync high at reset release SHALL NOT count as an edge.
REQ-005 The FSM SHALL have states IDLE, WRITE and DROP; reset state is IDLE.
REQ-006 IDLE SHALL ignore de.
- On a vsync edge: go to WRITE if fill < SLICES_IN_RAM, else go to DROP and set overrun.
REQ-007 In WRITE, each cycle with de=1 and pix_idx < IMAGE_SIZE SHALL issue exactly one RAM write and increment pix_idx.
REQ-008 Write latency SHALL be one cycle: a pixel sampled at edge N drives ram_we=1, ram_addr and ram_data from edge N+1 until edge N+2.
- ram_addr = RAM_BASE + wr_slot*IMAGE_SIZE + pix_idx, computed at full RAM_ADDR_WIDTH.
REQ-009 When the write of pixel IMAGE_SIZE-1 is issued, the slice SHALL commit on the same cycle:
- fill increments;
- wr_slot advances, wrapping from SLICES_IN_RAM-1 to 0;
- pix_idx clears;
- the FSM returns to IDLE.
REQ-010 de pulses in IDLE or DROP, or after commit and before the next vsync edge, SHALL be discarded with no write.
REQ-011 A vsync edge in WRITE with pix_idx < IMAGE_SIZE SHALL abort the slice:
- set frame_error, clear pix_idx, keep wr_slot and fill unchanged;
- restart WRITE into the same slot, with the same full check as REQ-006.
REQ-012 In DROP, the FSM SHALL return to IDLE logic on the next vsync edge, re-evaluating fill that same cycle.
REQ-013 A slice_consumed pulse SHALL decrement fill.
- A commit and a consume on the same cycle SHALL leave fill unchanged.
- A consume with fill=0 SHALL be ignored.
REQ-014 stream_ready SHALL be registered.
- It sets on the cycle after fill first reaches >= READY_SLICES.
- It clears on the cycle after fill reaches 0.
- Otherwise it holds.
REQ-015 overrun and frame_error SHALL stay high until reset.

Reset
REQ-016 A synchronous rst SHALL take precedence over every other input.
REQ-017 While rst is high the outputs SHALL be: ram_we=0, ram_addr=RAM_BASE, ram_data=0, fill=0, stream_ready=0, overrun=0, frame_error=0.
REQ-018 While rst is high the internal state SHALL be: state=IDLE, wr_slot=0, pix_idx=0, vsync register cleared.
REQ-019 rst asserted mid-slice SHALL discard the partial slice, and no ram_we SHALL occur on the cycle after rst is sampled.

Verification
REQ-020 Pack: vsync edge, then de=1 with rgb=24'hF8_FC_F8 -> next cycle ram_we=1, ram_addr=0, ram_data=16'hFFDF.
REQ-021 Two full slices (1920 de cycles each, defaults) -> the second slice starts at ram_addr=1920 and ends at 3839; fill=2; stream_ready=1 one cycle after the second commit.
REQ-022 Wrap: 18 slices with 17 slice_consumed pulses -> the 18th slice starts at address 17*1920=32640; the 19th starts at address 0; fill=2.
REQ-023 Full: 18 slices with no consume, then a 19th vsync and 1920 de cycles -> no ram_we, overrun=1, fill=18; one slice_consumed followed by a vsync -> writing resumes at slot 0.
REQ-024 Short frame: vsync edge after 100 pixels -> frame_error=1, fill unchanged, the next pixel writes to the slot base address; same-cycle commit and slice_consumed -> fill unchanged.
REQ-025 Reset mid-slice at pixel 500 -> all outputs at their reset values; the next slice starts at address RAM_BASE.
